mmio_port_responder: RTL and testbench

MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

---
 rtl/mmio_pkg.sv | 19 +
 rtl/mmio_timer.sv | 64 ++++++
 rtl/mmio_port_responder.sv | 96 +++++++++
 tb/tb_mmio_port_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, TMR_CTRL bit positions and default window base
// shared by the MMIO port responder and its timer.
package mmio_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1001_0040;

    localparam logic [2:0] OFF_PORT_OUT  = 3'd0;
    localparam logic [2:0] OFF_PORT_IN   = 3'd1;
    localparam logic [2:0] OFF_EDGE      = 3'd2;
    localparam logic [2:0] OFF_TMR_COUNT = 3'd3;
    localparam logic [2:0] OFF_TMR_CMP   = 3'd4;
    localparam logic [2:0] OFF_TMR_CTRL  = 3'd5;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_MATCH = 3;

endpackage

// File: rtl/mmio_timer.sv
// mmio_timer: free-running compare timer with auto-reload and a sticky MATCH flag;
// only instantiated when MMIO_TIMER_EN is defined.
module mmio_timer
    import mmio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_count_i,
    input  logic        wr_cmp_i,
    input  logic        wr_ctrl_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] cmp_o,
    output logic [3:0]  ctrl_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d, cmp_q, cmp_d;
    logic        en_q, en_d, ar_q, ar_d, ie_q, ie_d, match_q, match_d;
    logic        hit;

    assign hit = en_q && (count_q == cmp_q);

    // A software count write beats both increment and reload; a match beats a W1C.
    always_comb begin
        count_d = wr_count_i ? wdata_i : !en_q ? count_q : (hit && ar_q) ? 32'h0 : count_q + 32'd1;
        cmp_d   = wr_cmp_i ? wdata_i : cmp_q;
        en_d    = wr_ctrl_i ? wdata_i[CTRL_EN] : en_q;
        ar_d    = wr_ctrl_i ? wdata_i[CTRL_AR] : ar_q;
        ie_d    = wr_ctrl_i ? wdata_i[CTRL_IE] : ie_q;
        match_d = hit | (match_q & ~(wr_ctrl_i & wdata_i[CTRL_MATCH]));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            cmp_q   <= '0;
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            match_q <= 1'b0;
        end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            match_q <= match_d;
        end
    end

    always_comb begin
        ctrl_o              = 4'h0;
        ctrl_o[CTRL_EN]     = en_q;
        ctrl_o[CTRL_AR]     = ar_q;
        ctrl_o[CTRL_IE]     = ie_q;
        ctrl_o[CTRL_MATCH]  = match_q;
    end

    assign count_o = count_q;
    assign cmp_o   = cmp_q;
    assign irq_o   = match_q & ie_q;

endmodule

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: 32-byte MMIO window with output port, synchronized input
// port with rising-edge flags, and an optional timer enabled by MMIO_TIMER_EN.
module mmio_port_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        Irq
);

    logic [31:0] port_out_q, port_out_d;
    logic [7:0]  sync1_q, sync2_q, prev_q, flags_q, flags_d;
    logic [2:0]  off;
    logic        wr;
    logic        unused_addr;

    assign Hit         = Address[31:5] == BASE_ADDR[31:5];
    assign off         = Address[4:2];
    assign wr          = Hit && MemWrite;
    assign unused_addr = ^Address[1:0];

    // A rising edge seen this cycle wins over a same-cycle W1C of the flag.
    always_comb begin
        port_out_d = (wr && off == OFF_PORT_OUT) ? WriteData : port_out_q;
        flags_d    = (sync2_q & ~prev_q) | (flags_q & ~((wr && off == OFF_EDGE) ? WriteData[7:0] : 8'h0));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            port_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            flags_q    <= '0;
        end else begin
            port_out_q <= port_out_d;
            sync1_q    <= PortIn;
            sync2_q    <= sync1_q;
            prev_q     <= sync2_q;
            flags_q    <= flags_d;
        end
    end

`ifdef MMIO_TIMER_EN
    logic [31:0] tmr_count, tmr_cmp;
    logic [3:0]  tmr_ctrl;
    logic        tmr_irq;

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .wr_count_i (wr && off == OFF_TMR_COUNT),
        .wr_cmp_i   (wr && off == OFF_TMR_CMP),
        .wr_ctrl_i  (wr && off == OFF_TMR_CTRL),
        .wdata_i    (WriteData),
        .count_o    (tmr_count),
        .cmp_o      (tmr_cmp),
        .ctrl_o     (tmr_ctrl),
        .irq_o      (tmr_irq)
    );

    assign Irq = tmr_irq | (|flags_q);
`else
    assign Irq = |flags_q;
`endif

    always_comb begin
        ReadData = 32'h0;
        if (Hit && MemRead) begin
            case (off)
                OFF_PORT_OUT:  ReadData = port_out_q;
                OFF_PORT_IN:   ReadData = {24'h0, sync2_q};
                OFF_EDGE:      ReadData = {24'h0, flags_q};
`ifdef MMIO_TIMER_EN
                OFF_TMR_COUNT: ReadData = tmr_count;
                OFF_TMR_CMP:   ReadData = tmr_cmp;
                OFF_TMR_CTRL:  ReadData = {28'h0, tmr_ctrl};
`endif
                default:       ReadData = 32'h0;
            endcase
        end
    end

    assign PortOut = port_out_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: directed scenarios plus randomized bus/pin traffic
// checked against a behavioural register-map model (timer modelled when MMIO_TIMER_EN).
module tb_mmio_port_responder;

    localparam logic [31:0] BASE = 32'h1001_0040;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = '0, WriteData = '0;
    logic        MemWrite = 1'b0, MemRead = 1'b0;
    logic [7:0]  PortIn = '0;
    logic [31:0] ReadData, PortOut;
    logic        Hit, Irq;

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] m_port, m_count, m_cmp;
    logic [7:0]  m_flags;
    logic        m_en, m_ar, m_ie, m_match;
    logic [7:0]  pins[$];

    mmio_port_responder dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .ReadData  (ReadData),
        .Hit       (Hit),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .Irq       (Irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [7:0] sync_pins();
        int n = pins.size();
        return n >= 2 ? pins[n-2] : 8'h0;
    endfunction

    function automatic logic [7:0] prev_pins();
        int n = pins.size();
        return n >= 3 ? pins[n-3] : 8'h0;
    endfunction

    function automatic logic in_window(input logic [31:0] a);
        return a >= BASE && a < BASE + 32'd32;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic rd);
        if (!(in_window(a) && rd)) return 32'h0;
        case ((a - BASE) / 4)
            0: return m_port;
            1: return {24'h0, sync_pins()};
            2: return {24'h0, m_flags};
`ifdef MMIO_TIMER_EN
            3: return m_count;
            4: return m_cmp;
            5: return {28'h0, m_match, m_ie, m_ar, m_en};
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_port = 0; m_flags = 0; m_count = 0; m_cmp = 0;
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
        pins.delete();
    endtask

    task automatic model_step();
        logic w;
        int   o;
        logic m;
        w = in_window(Address) && MemWrite;
        o = (Address - BASE) / 4;
        m_flags = (sync_pins() & ~prev_pins()) | (m_flags & ~((w && o == 2) ? WriteData[7:0] : 8'h0));
        if (w && o == 0) m_port = WriteData;
`ifdef MMIO_TIMER_EN
        m = m_en && m_count == m_cmp;
        if (w && o == 3) m_count = WriteData;
        else if (m_en) m_count = (m && m_ar) ? 32'h0 : m_count + 1;
        if (w && o == 4) m_cmp = WriteData;
        m_match = m || (m_match && !(w && o == 5 && WriteData[3]));
        if (w && o == 5) begin
            m_en = WriteData[0]; m_ar = WriteData[1]; m_ie = WriteData[2];
        end
`endif
        pins.push_back(PortIn);
        if (pins.size() > 3) void'(pins.pop_front());
    endtask

    task automatic tick(input logic [31:0] a, input logic [31:0] wd, input logic mw, input logic mr, input logic [7:0] pin);
        Address = a; WriteData = wd; MemWrite = mw; MemRead = mr; PortIn = pin;
        #1;
        check("hit", {31'h0, Hit}, {31'h0, in_window(a)});
        check("rdata", ReadData, model_read(a, mr));
        check("portout", PortOut, m_port);
        check("irq", {31'h0, Irq}, {31'h0, (m_match && m_ie) || (|m_flags)});
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a; MemRead = 1'b1; MemWrite = 1'b0;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic do_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        check("rst_portout", PortOut, 32'h0);
        check("rst_irq", {31'h0, Irq}, 32'h0);
        peek("rst_count", BASE + 32'h0C, 32'h0);
        peek("rst_flags", BASE + 32'h08, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic rand_cycle();
        logic [31:0] a, wd;
        int r, o;
        r = $urandom_range(0, 9);
        o = $urandom_range(0, 7);
        a = r < 7 ? BASE + o * 4 + $urandom_range(0, 3) : r == 7 ? BASE + 32'h20 + $urandom_range(0, 31) : r == 8 ? $urandom : BASE - 4;
        wd = $urandom;
        if (o == 3 || o == 4) wd = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom_range(0, 40);
        if ($urandom_range(0, 15) == 0) PortIn = $urandom;
        tick(a, wd, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7, PortIn);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        check("init_portout", PortOut, 32'h0);
        check("init_irq", {31'h0, Irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        tick(BASE, 32'hA5A5_0001, 1, 0, 8'h00);
        check("w_portout", PortOut, 32'hA5A5_0001);
        peek("r_portout", BASE, 32'hA5A5_0001);
        check("r_hit", {31'h0, Hit}, 32'h1);

        tick(BASE + 4, 0, 0, 1, 8'h81);
        tick(BASE + 4, 0, 0, 1, 8'h81);
        peek("portin_2cyc", BASE + 4, 32'h81);
        tick(BASE + 8, 0, 0, 1, 8'h81);
        peek("edge_flags", BASE + 8, 32'h81);
        check("edge_irq", {31'h0, Irq}, 32'h1);

        tick(BASE + 8, 0, 0, 1, 8'h80);
        tick(BASE + 8, 0, 0, 1, 8'h80);
        tick(BASE + 8, 32'h1, 1, 1, 8'h80);
        peek("w1c_plain", BASE + 8, 32'h80);
        tick(BASE + 8, 0, 0, 1, 8'h81);
        tick(BASE + 8, 0, 0, 1, 8'h81);
        tick(BASE + 8, 32'h1, 1, 1, 8'h81);
        peek("w1c_vs_edge", BASE + 8, 32'h81);
        tick(BASE + 8, 32'h1, 1, 1, 8'h81);
        peek("w1c_no_edge", BASE + 8, 32'h80);
        tick(BASE + 8, 32'hFF, 1, 1, 8'h81);
        check("irq_cleared", {31'h0, Irq}, 32'h0);

        tick(BASE + 32'h20, 32'hDEAD_BEEF, 1, 1, 8'h81);
        tick(BASE + 32'h18, 32'hDEAD_BEEF, 1, 1, 8'h81);
        tick(BASE + 32'h1C, 32'hDEAD_BEEF, 1, 1, 8'h81);
        peek("outside_rd", BASE + 32'h20, 32'h0);
        check("outside_hit", {31'h0, Hit}, 32'h0);
        peek("resv_rd", BASE + 32'h18, 32'h0);
        check("resv_keep", PortOut, 32'hA5A5_0001);

`ifdef MMIO_TIMER_EN
        tick(BASE + 32'h10, 32'd5, 1, 0, 8'h81);
        tick(BASE + 32'h0C, 32'd0, 1, 0, 8'h81);
        tick(BASE + 32'h14, 32'h7, 1, 0, 8'h81);
        for (int i = 0; i < 8; i++) begin
            peek($sformatf("tmr_seq%0d", i), BASE + 32'h0C, i < 6 ? i : i - 6);
            tick(BASE, 0, 0, 0, 8'h81);
        end
        peek("tmr_match", BASE + 32'h14, 32'hF);
        check("tmr_irq", {31'h0, Irq}, 32'h1);
        tick(BASE + 32'h14, 32'hF, 1, 0, 8'h81);
        peek("tmr_w1c", BASE + 32'h14, 32'h7);
        tick(BASE + 32'h14, 32'h1, 1, 0, 8'h81);
        tick(BASE + 32'h0C, 32'hFFFF_FFFF, 1, 0, 8'h81);
        peek("tmr_max", BASE + 32'h0C, 32'hFFFF_FFFF);
        tick(BASE, 0, 0, 0, 8'h81);
        peek("tmr_wrap", BASE + 32'h0C, 32'h0);
        tick(BASE + 32'h0C, 32'd3, 1, 0, 8'h81);
        peek("tmr_at3", BASE + 32'h0C, 32'd3);
`else
        tick(BASE + 32'h0C, 32'h1234, 1, 0, 8'h81);
        tick(BASE + 32'h14, 32'h7, 1, 0, 8'h81);
        peek("notmr_count", BASE + 32'h0C, 32'h0);
        peek("notmr_ctrl", BASE + 32'h14, 32'h0);
`endif
        do_reset();
        tick(BASE, 0, 0, 0, 8'h00);
        tick(BASE, 0, 0, 0, 8'h00);
        peek("post_rst_count", BASE + 32'h0C, 32'h0);
        peek("post_rst_ctrl", BASE + 32'h14, 32'h0);

        for (int i = 0; i < 1500; i++) begin
            rand_cycle();
            if (i == 700) do_reset();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
